fp_sqrt_ctrl: RTL

Sequencing controller for the floating-point square-root datapath. It accepts a start request and drives the datapath's register-file addresses, ALU opcode and write enables through a Newton–Raphson sequence: seed, then `ITERATIONS` × (divide, add, halve). It uses the datapath status flags to short-circuit zero and negative operands. It reports completion through a ready/start/done handshake; the result is read from datapath R1.

---
 rtl/fp_sqrt_ctrl_if.sv | 60 ++++++
 rtl/fp_sqrt_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_ctrl_if.sv
// fp_sqrt_ctrl_if: handshake, status-flag and datapath-control bundle for the
// square-root sequencing controller. The optional conv_i convergence flag is
// present only when FP_SQRT_CTRL_EARLY_EXIT_EN is defined.
interface fp_sqrt_ctrl_if #(
    parameter int ADDR_WIDTH = 3
) ();
    logic                  start_i;
    logic                  negative_i;
    logic                  zero_i;
`ifdef FP_SQRT_CTRL_EARLY_EXIT_EN
    logic                  conv_i;
`endif
    logic                  ready_o;
    logic                  done_o;
    logic                  error_o;
    logic                  ld_operand_o;
    logic [ADDR_WIDTH-1:0] ra_addr_o;
    logic [ADDR_WIDTH-1:0] rb_addr_o;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic                  wr_en_o;
    logic [2:0]            alu_op_o;

    // Controller side: consumes requests and flags, drives the datapath.
    modport master (
        input  start_i,
        input  negative_i,
        input  zero_i,
`ifdef FP_SQRT_CTRL_EARLY_EXIT_EN
        input  conv_i,
`endif
        output ready_o,
        output done_o,
        output error_o,
        output ld_operand_o,
        output ra_addr_o,
        output rb_addr_o,
        output wr_addr_o,
        output wr_en_o,
        output alu_op_o
    );

    // Requester/datapath side.
    modport slave (
        output start_i,
        output negative_i,
        output zero_i,
`ifdef FP_SQRT_CTRL_EARLY_EXIT_EN
        output conv_i,
`endif
        input  ready_o,
        input  done_o,
        input  error_o,
        input  ld_operand_o,
        input  ra_addr_o,
        input  rb_addr_o,
        input  wr_addr_o,
        input  wr_en_o,
        input  alu_op_o
    );
endinterface

// File: rtl/fp_sqrt_ctrl.sv
// fp_sqrt_ctrl: sequencing controller for the floating-point square-root
// datapath. Runs seed + ITERATIONS x (divide, add, halve) Newton-Raphson steps,
// short-circuits zero and negative operands, and reports through a
// ready/start/done handshake. The result lives in datapath R1.
// Register use: R0 = operand, R1 = estimate/result, R2 = temporary.
// Optional feature: define FP_SQRT_CTRL_EARLY_EXIT_EN to add conv_i, which ends
// the iteration loop early when the HALF write-back did not change R1.
// All outputs are registered; nothing combinational runs from inputs to outputs.
module fp_sqrt_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int ITERATIONS  = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_sqrt_ctrl_if.master   bus
);

    // Reject parameter values the sequencing cannot honour.
    if (DATA_WIDTH < 1 || ADDR_WIDTH < 2 || ITERATIONS < 1 || ITERATIONS > 15 ||
        ALU_LATENCY < 1) begin : g_bad_params
        $error("fp_sqrt_ctrl: illegal parameter value");
    end

    localparam int HOLD_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(ALU_LATENCY - 1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_HALF = 3'b011;
    localparam logic [2:0] OP_SEED = 3'b100;
    localparam logic [2:0] OP_QNAN = 3'b110;

    localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] R1 = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] R2 = ADDR_WIDTH'(2);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CHECK, S_SEED, S_DIV, S_ADD, S_HALF, S_ZERO, S_NAN, S_DONE
    } state_t;

    // Datapath control word held for the whole of a state.
    typedef struct packed {
        logic                  ld;
        logic [2:0]            op;
        logic [ADDR_WIDTH-1:0] ra;
        logic [ADDR_WIDTH-1:0] rb;
        logic [ADDR_WIDTH-1:0] wa;
    } ctl_t;

    // Control word for each state; unused operand addresses stay 0.
    function automatic ctl_t ctl_for(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_LOAD:  c.ld = 1'b1;
            S_SEED:  begin c.op = OP_SEED; c.ra = R0;             c.wa = R1; end
            S_DIV:   begin c.op = OP_DIV;  c.ra = R0; c.rb = R1;  c.wa = R2; end
            S_ADD:   begin c.op = OP_ADD;  c.ra = R1; c.rb = R2;  c.wa = R2; end
            S_HALF:  begin c.op = OP_HALF; c.ra = R2;             c.wa = R1; end
            S_ZERO:  begin c.op = OP_PASS; c.ra = R0;             c.wa = R1; end
            S_NAN:   begin c.op = OP_QNAN;                        c.wa = R1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_op(state_t s);
        return s inside {S_SEED, S_DIV, S_ADD, S_HALF, S_ZERO, S_NAN};
    endfunction

    state_t            state;
    state_t            nxt_state;
    logic [HOLD_W-1:0] hold;
    logic [3:0]        iter;
    ctl_t              ctl;
    logic              wr_en;
    logic              ready;
    logic              done;
    logic              error;

    logic hold_last;
    logic iter_done;
    logic conv_hit;
    logic entering;
    logic nxt_wr;

    assign hold_last = (hold == '0);
    assign iter_done = ({1'b0, iter} + 5'd1) >= 5'(ITERATIONS);
    assign entering  = (nxt_state != state);

`ifdef FP_SQRT_CTRL_EARLY_EXIT_EN
    assign conv_hit = bus.conv_i;
`else
    assign conv_hit = 1'b0;
`endif

    // Write enable for the coming cycle: last hold cycle of an op state.
    assign nxt_wr = is_op(nxt_state) &&
                    (entering ? (ALU_LATENCY == 1) : (hold == HOLD_W'(1)));

    // Next-state decode; op states advance only in their last hold cycle.
    always_comb begin
        // NOTE: default first so every path assigns nxt_state and no latch forms.
        nxt_state = state;
        case (state)
            S_IDLE:  if (bus.start_i) nxt_state = S_LOAD;
            S_LOAD:  nxt_state = S_CHECK;
            S_CHECK: begin
                if (bus.zero_i)          nxt_state = S_ZERO;
                else if (bus.negative_i) nxt_state = S_NAN;
                else                     nxt_state = S_SEED;
            end
            S_SEED:  if (hold_last) nxt_state = S_DIV;
            S_DIV:   if (hold_last) nxt_state = S_ADD;
            S_ADD:   if (hold_last) nxt_state = S_HALF;
            S_HALF:  if (hold_last) nxt_state = (iter_done || conv_hit) ? S_DONE : S_DIV;
            S_ZERO:  if (hold_last) nxt_state = S_DONE;
            S_NAN:   if (hold_last) nxt_state = S_DONE;
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // State, hold/iteration counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every register sees pre-edge values.
        if (!rst_n) begin
            state <= S_IDLE;
            hold  <= '0;
            iter  <= '0;
            ctl   <= '0;
            wr_en <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= nxt_state;
            ctl   <= ctl_for(nxt_state);
            wr_en <= nxt_wr;
            ready <= (nxt_state == S_IDLE);
            done  <= (nxt_state == S_DONE);
            error <= (nxt_state == S_DONE) && (state == S_NAN);

            if (entering)        hold <= HOLD_RELOAD;
            else if (!hold_last) hold <= hold - HOLD_W'(1);

            if (state == S_SEED)                  iter <= '0;
            else if (state == S_HALF && hold_last) iter <= iter + 4'd1;
        end
    end

    assign bus.ready_o      = ready;
    assign bus.done_o       = done;
    assign bus.error_o      = error;
    assign bus.ld_operand_o = ctl.ld;
    assign bus.alu_op_o     = ctl.op;
    assign bus.ra_addr_o    = ctl.ra;
    assign bus.rb_addr_o    = ctl.rb;
    assign bus.wr_addr_o    = ctl.wa;
    assign bus.wr_en_o      = wr_en;

endmodule
